// File: rtl/alu_rs_if.sv
// Issue, CDB snoop and ALU-feed bundle for the ALU reservation station.
// The master side (dispatch/ROB) drives issue and CDB; the slave (alu_rs) drives exec and rs_full.
interface alu_rs_if #(
  parameter int ROB_W = 4
);
  logic             issue_valid;
  logic [5:0]       issue_op;
  logic [31:0]      issue_vj;
  logic [ROB_W-1:0] issue_qj;
  logic             issue_qj_busy;
  logic [31:0]      issue_vk;
  logic [ROB_W-1:0] issue_qk;
  logic             issue_qk_busy;
  logic [ROB_W-1:0] issue_rob_id;

  logic             cdb_valid;
  logic [ROB_W-1:0] cdb_rob_id;
  logic [31:0]      cdb_value;

  logic             rs_full;
  logic             exec_valid;
  logic [5:0]       exec_op;
  logic [31:0]      exec_rs1;
  logic [31:0]      exec_rs2;
  logic [ROB_W-1:0] exec_rob_id;

  modport master (
    output issue_valid, issue_op, issue_vj, issue_qj, issue_qj_busy,
           issue_vk, issue_qk, issue_qk_busy, issue_rob_id,
           cdb_valid, cdb_rob_id, cdb_value,
    input  rs_full, exec_valid, exec_op, exec_rs1, exec_rs2, exec_rob_id
  );

  modport slave (
    input  issue_valid, issue_op, issue_vj, issue_qj, issue_qj_busy,
           issue_vk, issue_qk, issue_qk_busy, issue_rob_id,
           cdb_valid, cdb_rob_id, cdb_value,
    output rs_full, exec_valid, exec_op, exec_rs1, exec_rs2, exec_rob_id
  );
endinterface

// File: rtl/alu_rs.sv
// ALU reservation station: holds instructions until both operands arrive (CDB wakeup),
// then feeds the lowest-index ready entry to the ALU through registered exec outputs.
module alu_rs #(
  parameter int RS_SIZE = 8,
  parameter int ROB_W   = 4
) (
  input  logic     clk_in,
  input  logic     rst_in,
  input  logic     rdy_in,
  input  logic     clear_in,
  alu_rs_if.slave  bus
);
  localparam int IDX_W = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;

  logic [RS_SIZE-1:0] busy_q, busy_d;
  logic [RS_SIZE-1:0] qj_busy_q, qj_busy_d;
  logic [RS_SIZE-1:0] qk_busy_q, qk_busy_d;
  logic [5:0]         op_q  [RS_SIZE];
  logic [5:0]         op_d  [RS_SIZE];
  logic [31:0]        vj_q  [RS_SIZE];
  logic [31:0]        vj_d  [RS_SIZE];
  logic [31:0]        vk_q  [RS_SIZE];
  logic [31:0]        vk_d  [RS_SIZE];
  logic [ROB_W-1:0]   qj_q  [RS_SIZE];
  logic [ROB_W-1:0]   qj_d  [RS_SIZE];
  logic [ROB_W-1:0]   qk_q  [RS_SIZE];
  logic [ROB_W-1:0]   qk_d  [RS_SIZE];
  logic [ROB_W-1:0]   rob_q [RS_SIZE];
  logic [ROB_W-1:0]   rob_d [RS_SIZE];

  logic               exec_valid_q, exec_valid_d;
  logic [5:0]         exec_op_q, exec_op_d;
  logic [31:0]        exec_rs1_q, exec_rs1_d;
  logic [31:0]        exec_rs2_q, exec_rs2_d;
  logic [ROB_W-1:0]   exec_rob_id_q, exec_rob_id_d;

  logic [RS_SIZE-1:0] ready_vec;
  logic               free_found, sel_found;
  logic [IDX_W-1:0]   free_idx, sel_idx;

  // Both searches look only at registered state, so a slot freed by this edge's
  // dispatch is never handed to a same-edge issue.
  assign ready_vec = busy_q & ~qj_busy_q & ~qk_busy_q;

  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    sel_found  = 1'b0;
    sel_idx    = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (!busy_q[i]) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
      if (ready_vec[i]) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(i);
      end
    end
  end

  always_comb begin
    busy_d        = busy_q;
    qj_busy_d     = qj_busy_q;
    qk_busy_d     = qk_busy_q;
    op_d          = op_q;
    vj_d          = vj_q;
    vk_d          = vk_q;
    qj_d          = qj_q;
    qk_d          = qk_q;
    rob_d         = rob_q;
    exec_valid_d  = exec_valid_q;
    exec_op_d     = exec_op_q;
    exec_rs1_d    = exec_rs1_q;
    exec_rs2_d    = exec_rs2_q;
    exec_rob_id_d = exec_rob_id_q;

    if (rdy_in) begin
      if (clear_in) begin
        busy_d       = '0;
        exec_valid_d = 1'b0;
        exec_op_d    = '0;
      end else begin
        if (bus.cdb_valid) begin
          for (int i = 0; i < RS_SIZE; i++) begin
            if (busy_q[i] && qj_busy_q[i] && (qj_q[i] == bus.cdb_rob_id)) begin
              vj_d[i]      = bus.cdb_value;
              qj_busy_d[i] = 1'b0;
            end
            if (busy_q[i] && qk_busy_q[i] && (qk_q[i] == bus.cdb_rob_id)) begin
              vk_d[i]      = bus.cdb_value;
              qk_busy_d[i] = 1'b0;
            end
          end
        end

        if (sel_found) begin
          exec_valid_d      = 1'b1;
          exec_op_d         = op_q[sel_idx];
          exec_rs1_d        = vj_q[sel_idx];
          exec_rs2_d        = vk_q[sel_idx];
          exec_rob_id_d     = rob_q[sel_idx];
          busy_d[sel_idx]   = 1'b0;
        end else begin
          exec_valid_d = 1'b0;
          exec_op_d    = '0;
        end

        // Issue while full is silently dropped.
        if (bus.issue_valid && free_found) begin
          busy_d[free_idx]    = 1'b1;
          op_d[free_idx]      = bus.issue_op;
          rob_d[free_idx]     = bus.issue_rob_id;
          qj_d[free_idx]      = bus.issue_qj;
          qk_d[free_idx]      = bus.issue_qk;
          vj_d[free_idx]      = bus.issue_vj;
          vk_d[free_idx]      = bus.issue_vk;
          qj_busy_d[free_idx] = bus.issue_qj_busy;
          qk_busy_d[free_idx] = bus.issue_qk_busy;
          if (bus.issue_qj_busy && bus.cdb_valid && (bus.cdb_rob_id == bus.issue_qj)) begin
            vj_d[free_idx]      = bus.cdb_value;
            qj_busy_d[free_idx] = 1'b0;
          end
          if (bus.issue_qk_busy && bus.cdb_valid && (bus.cdb_rob_id == bus.issue_qk)) begin
            vk_d[free_idx]      = bus.cdb_value;
            qk_busy_d[free_idx] = 1'b0;
          end
        end
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      busy_q        <= '0;
      qj_busy_q     <= '0;
      qk_busy_q     <= '0;
      for (int i = 0; i < RS_SIZE; i++) begin
        op_q[i]  <= '0;
        vj_q[i]  <= '0;
        vk_q[i]  <= '0;
        qj_q[i]  <= '0;
        qk_q[i]  <= '0;
        rob_q[i] <= '0;
      end
      exec_valid_q  <= 1'b0;
      exec_op_q     <= '0;
      exec_rs1_q    <= '0;
      exec_rs2_q    <= '0;
      exec_rob_id_q <= '0;
    end else begin
      busy_q        <= busy_d;
      qj_busy_q     <= qj_busy_d;
      qk_busy_q     <= qk_busy_d;
      op_q          <= op_d;
      vj_q          <= vj_d;
      vk_q          <= vk_d;
      qj_q          <= qj_d;
      qk_q          <= qk_d;
      rob_q         <= rob_d;
      exec_valid_q  <= exec_valid_d;
      exec_op_q     <= exec_op_d;
      exec_rs1_q    <= exec_rs1_d;
      exec_rs2_q    <= exec_rs2_d;
      exec_rob_id_q <= exec_rob_id_d;
    end
  end

  assign bus.rs_full     = &busy_q;
  assign bus.exec_valid  = exec_valid_q;
  assign bus.exec_op     = exec_op_q;
  assign bus.exec_rs1    = exec_rs1_q;
  assign bus.exec_rs2    = exec_rs2_q;
  assign bus.exec_rob_id = exec_rob_id_q;
endmodule

// File: tb/tb_alu_rs.sv
// Directed bench for alu_rs: issue, wakeup, bypass, full/ordering, flush, stall and async reset.
module tb_alu_rs;
  logic clk_in = 1'b0;
  logic rst_in;
  logic rdy_in;
  logic clear_in;
  int   n_tests = 0;
  int   n_fail  = 0;

  alu_rs_if #(.ROB_W(4)) bus ();

  alu_rs #(.RS_SIZE(8), .ROB_W(4)) dut (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .rdy_in   (rdy_in),
    .clear_in (clear_in),
    .bus      (bus)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, then drop single-cycle strobes.
  task automatic step();
    @(posedge clk_in);
    #1;
    bus.issue_valid = 1'b0;
    bus.cdb_valid   = 1'b0;
    clear_in        = 1'b0;
  endtask

  task automatic set_issue(input logic [5:0] op, input logic [31:0] vj, input logic [3:0] qj,
                           input logic qjb, input logic [31:0] vk, input logic [3:0] qk,
                           input logic qkb, input logic [3:0] rob);
    bus.issue_valid   = 1'b1;
    bus.issue_op      = op;
    bus.issue_vj      = vj;
    bus.issue_qj      = qj;
    bus.issue_qj_busy = qjb;
    bus.issue_vk      = vk;
    bus.issue_qk      = qk;
    bus.issue_qk_busy = qkb;
    bus.issue_rob_id  = rob;
    $display("[TB] issue op=%0d rob=%0d qj_busy=%0d qk_busy=%0d", op, rob, qjb, qkb);
  endtask

  task automatic set_cdb(input logic [3:0] tag, input logic [31:0] val);
    bus.cdb_valid  = 1'b1;
    bus.cdb_rob_id = tag;
    bus.cdb_value  = val;
    $display("[TB] cdb tag=%0d value=0x%0h", tag, val);
  endtask

  initial begin
    rst_in   = 1'b0;
    rdy_in   = 1'b1;
    clear_in = 1'b0;
    bus.issue_valid = 1'b0;
    bus.issue_op = '0; bus.issue_vj = '0; bus.issue_qj = '0; bus.issue_qj_busy = 1'b0;
    bus.issue_vk = '0; bus.issue_qk = '0; bus.issue_qk_busy = 1'b0; bus.issue_rob_id = '0;
    bus.cdb_valid = 1'b0; bus.cdb_rob_id = '0; bus.cdb_value = '0;

    #12;
    check("rst_exec_valid", bus.exec_valid, 0);
    check("rst_exec_op", bus.exec_op, 0);
    check("rst_exec_rs1", bus.exec_rs1, 0);
    check("rst_exec_rs2", bus.exec_rs2, 0);
    check("rst_exec_rob", bus.exec_rob_id, 0);
    check("rst_full", bus.rs_full, 0);
    rst_in = 1'b1;
    step();

    // Ready at issue: written at edge 1, dispatched at edge 2.
    set_issue(6'd1, 32'd5, 4'd0, 1'b0, 32'd7, 4'd0, 1'b0, 4'd1);
    step();
    check("ready_not_early", bus.exec_valid, 0);
    step();
    check("ready_valid", bus.exec_valid, 1);
    check("ready_op", bus.exec_op, 1);
    check("ready_rs1", bus.exec_rs1, 5);
    check("ready_rs2", bus.exec_rs2, 7);
    check("ready_rob", bus.exec_rob_id, 1);
    step();
    check("ready_one_cycle", bus.exec_valid, 0);
    check("ready_op_zero", bus.exec_op, 0);
    check("ready_rs1_hold", bus.exec_rs1, 5);

    // Wakeup through CDB two cycles after issue.
    set_issue(6'd2, 32'd0, 4'd3, 1'b1, 32'd1, 4'd0, 1'b0, 4'd4);
    step();
    step();
    check("wake_waiting", bus.exec_valid, 0);
    set_cdb(4'd3, 32'h10);
    step();
    check("wake_not_early", bus.exec_valid, 0);
    step();
    check("wake_valid", bus.exec_valid, 1);
    check("wake_rs1", bus.exec_rs1, 32'h10);
    check("wake_rs2", bus.exec_rs2, 1);
    check("wake_rob", bus.exec_rob_id, 4);
    step();

    // Issue-time bypass on operand 2.
    set_issue(6'd3, 32'd9, 4'd0, 1'b0, 32'd0, 4'd6, 1'b1, 4'd5);
    set_cdb(4'd6, 32'hABCD);
    step();
    check("byp_not_early", bus.exec_valid, 0);
    step();
    check("byp_valid", bus.exec_valid, 1);
    check("byp_rs1", bus.exec_rs1, 9);
    check("byp_rs2", bus.exec_rs2, 32'hABCD);
    step();

    // Fill all 8 entries waiting on tag 2, then a dropped 9th issue.
    for (int i = 0; i < 8; i++) begin
      set_issue(6'd4, 32'd0, 4'd2, 1'b1, 32'(i), 4'd0, 1'b0, 4'(i));
      step();
    end
    check("full_set", bus.rs_full, 1);
    set_issue(6'd5, 32'd1, 4'd0, 1'b0, 32'd2, 4'd0, 1'b0, 4'd9);
    step();
    check("full_still", bus.rs_full, 1);
    check("full_no_exec", bus.exec_valid, 0);
    set_cdb(4'd2, 32'h22);
    step();
    check("full_wake_edge", bus.exec_valid, 0);
    for (int k = 0; k < 8; k++) begin
      step();
      check("order_valid", bus.exec_valid, 1);
      check("order_rob", bus.exec_rob_id, 32'(k));
      check("order_rs1", bus.exec_rs1, 32'h22);
      check("order_rs2", bus.exec_rs2, 32'(k));
      if (k == 0) check("full_cleared", bus.rs_full, 0);
    end
    step();
    check("ninth_dropped", bus.exec_valid, 0);

    // Flush with simultaneous issue.
    set_issue(6'd6, 32'd0, 4'd7, 1'b1, 32'd0, 4'd0, 1'b0, 4'd10);
    step();
    set_issue(6'd6, 32'd0, 4'd8, 1'b1, 32'd0, 4'd0, 1'b0, 4'd11);
    step();
    set_issue(6'd6, 32'd0, 4'd9, 1'b1, 32'd0, 4'd0, 1'b0, 4'd12);
    step();
    set_issue(6'd7, 32'd3, 4'd0, 1'b0, 32'd4, 4'd0, 1'b0, 4'd13);
    clear_in = 1'b1;
    step();
    check("flush_valid", bus.exec_valid, 0);
    check("flush_full", bus.rs_full, 0);
    step();
    check("flush_issue_dropped", bus.exec_valid, 0);
    set_cdb(4'd7, 32'h77);
    step();
    set_cdb(4'd8, 32'h88);
    step();
    check("flush_old_tag_a", bus.exec_valid, 0);
    step();
    check("flush_old_tag_b", bus.exec_valid, 0);

    // Stall: exec frozen while rdy_in is low.
    set_issue(6'd8, 32'h11, 4'd0, 1'b0, 32'h22, 4'd0, 1'b0, 4'd14);
    step();
    set_issue(6'd9, 32'h33, 4'd0, 1'b0, 32'h44, 4'd0, 1'b0, 4'd15);
    step();
    check("stall_pre_rob", bus.exec_rob_id, 14);
    rdy_in = 1'b0;
    step();
    check("stall_valid", bus.exec_valid, 1);
    check("stall_rob", bus.exec_rob_id, 14);
    step();
    check("stall_rob2", bus.exec_rob_id, 14);
    check("stall_op", bus.exec_op, 8);
    rdy_in = 1'b1;
    step();
    check("stall_resume_rob", bus.exec_rob_id, 15);
    check("stall_resume_rs1", bus.exec_rs1, 32'h33);
    step();
    check("stall_drain", bus.exec_valid, 0);

    // Async reset mid-cycle with one entry still pending.
    set_issue(6'd10, 32'h5, 4'd0, 1'b0, 32'h6, 4'd0, 1'b0, 4'd2);
    step();
    set_issue(6'd11, 32'h7, 4'd0, 1'b0, 32'h8, 4'd0, 1'b0, 4'd6);
    step();
    check("arst_pre_valid", bus.exec_valid, 1);
    #2;
    rst_in = 1'b0;
    #1;
    check("arst_valid", bus.exec_valid, 0);
    check("arst_rob", bus.exec_rob_id, 0);
    check("arst_rs1", bus.exec_rs1, 0);
    #2;
    rst_in = 1'b1;
    step();
    check("arst_cleared", bus.exec_valid, 0);
    step();
    check("arst_cleared2", bus.exec_valid, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
